vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator and pixel pipeline; successor to the fixed 640x480 counter pair and top. It produces hsync/vsync with configurable porch, sync width and polarity, exports active-area pixel coordinates to the pixel source, and blanks or overrides the returned colour. Built-in test patterns allow bring-up without the game-of-life engine. It sits between the cell-memory renderer and the board VGA pins.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: hsync width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch
- V_SYNC, 2: vsync width
- V_BP, 33: vertical back porch
- HS_POL, 1: hsync active level
- VS_POL, 1: vsync active level
- CNT_W, 10: counter and coordinate width
- CHECK_LOG2, 4: log2 of the checkerboard square size
---
- clk  in  1  system clock; every always block runs on posedge clk
- reset  in  1  synchronous, active-high
- use_enable  in  1  pixel-rate clock enable; one pixel per enabled cycle
- mode  in  2  0 passthrough, 1 solid white, 2 colour bars, 3 checkerboard
- rgb_in  in  12  {r,g,b} from the pixel source for the current pixel_x/pixel_y
- pixel_x  out  CNT_W  active-area x; combinational from counters
- pixel_y  out  CNT_W  active-area y; combinational from counters
- pixel_req  out  1  current counter position is in the active area; combinational
- hsync_vga, vsync_vga  out  1  registered sync outputs
- r_vga, g_vga, b_vga  out  4  registered colour outputs
- frame_start  out  1  one-clk pulse, registered

## Operation
- Line layout: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. The sync pulse starts at h_count 0, then back porch, then active, then front porch. The vertical layout is the same: V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Both totals must be ≤ 2^CNT_W, and H_ACTIVE must be a multiple of 8. Violating either is an elaboration error, raised with a generate-time check.
- On every clk with use_enable=1:
  - h_count increments and wraps from H_TOTAL-1 to 0.
  - v_count increments only on the h wrap, and wraps from V_TOTAL-1 to 0.
- With use_enable=0 the counters and all registered outputs hold.
- pixel_req = 1 when H_SYNC+H_BP ≤ h_count < H_SYNC+H_BP+H_ACTIVE and the same window condition holds for v_count.
  - pixel_x = h_count-(H_SYNC+H_BP) and pixel_y = v_count-(V_SYNC+V_BP) when pixel_req=1.
  - Both are 0 when pixel_req=0.
- Registered stage, updated on an enabled clk from the current counters:
  - hsync_vga = HS_POL when h_count < H_SYNC, else ~HS_POL.
  - vsync_vga = VS_POL when v_count < V_SYNC, else ~VS_POL.
  - Colour is 0 when pixel_req=0; otherwise it is set by the latched mode.
- Colour by latched mode:
  - Mode 0: rgb_in.
  - Mode 1: 12'hFFF.
  - Mode 2: eight equal bars of H_ACTIVE/8 pixels, left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. The bar index comes from a bar counter, not a divider. The bar counter resets at each line's first active pixel.
  - Mode 3: FFF when pixel_x[CHECK_LOG2] xor pixel_y[CHECK_LOG2] is 1, else 000.
- Mode latch: mode is sampled only on an enabled clk with h_count=0 and v_count=0. A mid-frame change takes effect at the next frame.
- frame_start: asserted for exactly one clk after an enabled clk with h_count=0 and v_count=0. It is low on every other clk, including held (use_enable=0) clks.

## Timing
- Reset values:
  - h_count = 0, v_count = 0, latched mode = 0.
  - hsync_vga = ~HS_POL, vsync_vga = ~VS_POL.
  - r_vga, g_vga and b_vga = 0; frame_start = 0.
- Reset asserted mid-frame returns the block to these values on the next clk. The first enabled clk after reset is pixel (0,0) and produces a frame_start pulse.
- Latency: the registered outputs show counter position N one enabled clk after position N. Sync and colour stay mutually aligned.
- The pixel source must drive rgb_in combinationally from pixel_x/pixel_y within the same clk; rgb_in is sampled on that enabled edge.
- Defaults give 800x525 enabled clks per frame. The first active pixel is at h=144, v=35; the last is at h=783, v=514.

## Test plan
- Default params, use_enable=1 constantly, mode=1:
  - 800 clks per line and 420000 clks per frame.
  - hsync_vga is high for 96 consecutive clks per line and vsync_vga is high for 2 lines.
  - Colour is FFF exactly for h 144..783, v 35..514, delayed one clk.
- use_enable pulsed 1-in-4:
  - Line length is 3200 clks.
  - Outputs hold between enables and frame_start stays 1 clk wide.
- mode=0 with rgb_in = {pixel_x[3:0], pixel_y[3:0], 4'h5}: the output at active (x=10, y=3) is 12'hA35, one enabled clk later.
- mode=2: the first active pixel of each line is FFF, pixel_x=80 is FF0, and pixel_x=639 is 000.
- Mode change to 3 at v=200: the current frame is unchanged. In the next frame, pixel (16,0) is FFF and pixel (16,16) is 000.
- HS_POL=0, VS_POL=0, with reset asserted at v=300 for 1 clk:
  - Sync outputs read 1 in reset and the counters restart at 0.
  - frame_start fires on the clk after the first enabled clk after reset.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync/porch counters, active-area pixel
// coordinates, and a registered colour stage with built-in test patterns.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   CNT_W      = 10,
    parameter int   CHECK_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             use_enable,
    input  logic [1:0]       mode,
    input  logic [11:0]      rgb_in,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pixel_req,
    output logic             hsync_vga,
    output logic             vsync_vga,
    output logic [3:0]       r_vga,
    output logic [3:0]       g_vga,
    output logic [3:0]       b_vga,
    output logic             frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int BAR_W   = H_ACTIVE / 8;

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) || (H_ACTIVE % 8) != 0) begin : g_bad_params
        $error("vga_timing_gen: totals exceed 2**CNT_W or H_ACTIVE is not a multiple of 8");
    end

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_WHITE = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    mode_e            mode_q;
    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_idx;

    logic             h_in;
    logic             v_in;
    logic             at_origin;
    logic             bar_first;
    logic [CNT_W-1:0] cur_px;
    logic [2:0]       cur_idx;
    logic [11:0]      colour_next;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        h_in      = (int'(h_count) >= H_START) && (int'(h_count) < H_END);
        v_in      = (int'(v_count) >= V_START) && (int'(v_count) < V_END);
        pixel_req = h_in && v_in;
        at_origin = (h_count == '0) && (v_count == '0);
        pixel_x   = '0;
        pixel_y   = '0;
        if (pixel_req) begin
            pixel_x = h_count - CNT_W'(H_START);
            pixel_y = v_count - CNT_W'(V_START);
        end
        // The bar counter restarts on the first active pixel of every line.
        bar_first = (int'(h_count) == H_START);
        cur_px    = bar_first ? '0 : bar_px;
        cur_idx   = bar_first ? 3'd0 : bar_idx;

        colour_next = 12'h000;
        if (pixel_req) begin
            case (mode_q)
                MODE_PASS:  colour_next = rgb_in;
                MODE_WHITE: colour_next = 12'hFFF;
                MODE_BARS:  colour_next = bar_colour(cur_idx);
                MODE_CHECK: colour_next = (pixel_x[CHECK_LOG2] ^ pixel_y[CHECK_LOG2]) ? 12'hFFF : 12'h000;
                default:    colour_next = 12'h000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            mode_q      <= MODE_PASS;
            bar_px      <= '0;
            bar_idx     <= 3'd0;
            hsync_vga   <= ~HS_POL;
            vsync_vga   <= ~VS_POL;
            {r_vga, g_vga, b_vga} <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (use_enable) begin
                if (int'(h_count) == H_TOTAL - 1) begin
                    h_count <= '0;
                    v_count <= (int'(v_count) == V_TOTAL - 1) ? '0 : v_count + CNT_W'(1);
                end else begin
                    h_count <= h_count + CNT_W'(1);
                end

                if (at_origin) begin
                    mode_q      <= mode_e'(mode);
                    frame_start <= 1'b1;
                end

                if (h_in) begin
                    if (int'(cur_px) == BAR_W - 1) begin
                        bar_px  <= '0;
                        bar_idx <= cur_idx + 3'd1;
                    end else begin
                        bar_px  <= cur_px + CNT_W'(1);
                        bar_idx <= cur_idx;
                    end
                end

                hsync_vga <= (int'(h_count) < H_SYNC) ? HS_POL : ~HS_POL;
                vsync_vga <= (int'(v_count) < V_SYNC) ? VS_POL : ~VS_POL;
                {r_vga, g_vga, b_vga} <= colour_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 82x47 raster: sync widths,
// frame length, patterns, clock-enable holding, mode latching and reset.
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 6;
    localparam int VA = 40, VF = 2, VS = 2, VB = 3;
    localparam int HT = HS + HB + HA + HF;   // 82
    localparam int VT = VS + VB + VA + VF;   // 47
    localparam int HST = HS + HB;            // 14
    localparam int VST = VS + VB;            // 5

    logic        clk = 1'b0;
    logic        reset, reset_b, use_enable;
    logic [1:0]  mode;
    logic [11:0] rgb_in_a;

    logic [9:0]  pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
    logic        pixel_req_a, pixel_req_b;
    logic        hs_a, vs_a, hs_b, vs_b, fs_a, fs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;
    int cur_h = 0, cur_v = 0, shown_h = 0, shown_v = 0;

    always #5 clk = ~clk;

    assign rgb_in_a = {pixel_x_a[3:0], pixel_y_a[3:0], 4'h5};

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10), .CHECK_LOG2(4)
    ) dut_a (
        .clk(clk), .reset(reset), .use_enable(use_enable), .mode(mode), .rgb_in(rgb_in_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .pixel_req(pixel_req_a),
        .hsync_vga(hs_a), .vsync_vga(vs_a), .r_vga(r_a), .g_vga(g_a), .b_vga(b_a),
        .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10), .CHECK_LOG2(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .use_enable(use_enable), .mode(mode), .rgb_in(12'h000),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .pixel_req(pixel_req_b),
        .hsync_vga(hs_b), .vsync_vga(vs_b), .r_vga(r_b), .g_vga(g_b), .b_vga(b_b),
        .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] col_a();
        return {r_a, g_a, b_a};
    endfunction

    // One clock; the raster model advances only on enabled clocks. Outputs are sampled 2ns after the edge.
    task automatic tick(input logic en);
        use_enable = en;
        @(posedge clk);
        if (en) begin
            shown_h = cur_h;
            shown_v = cur_v;
            if (cur_h == HT - 1) begin
                cur_h = 0;
                cur_v = (cur_v == VT - 1) ? 0 : cur_v + 1;
            end else begin
                cur_h = cur_h + 1;
            end
        end
        #2;
    endtask

    // Leaves the registered outputs showing position (h,v).
    task automatic advance_to(input int h, input int v);
        int n = 0;
        while (!(cur_h == h && cur_v == v) && n < 5000) begin
            tick(1'b1);
            n++;
        end
        check("reach_pos", 32'(cur_h == h && cur_v == v), 32'd1);
        tick(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_hi, vs_hi, fs_cnt, white, map_err, hold_err, clk_idx, rise0, rise1;
        logic prev_hs, exp_act;
        logic [13:0] snap;

        reset = 1'b1; reset_b = 1'b1; use_enable = 1'b1; mode = 2'd1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_hs_a", 32'(hs_a), 32'd0);
        check("rst_vs_a", 32'(vs_a), 32'd0);
        check("rst_col_a", 32'(col_a()), 32'h000);
        check("rst_fs_a", 32'(fs_a), 32'd0);
        check("rst_req_a", 32'(pixel_req_a), 32'd0);
        check("rst_hs_b", 32'(hs_b), 32'd1);
        check("rst_vs_b", 32'(vs_b), 32'd1);
        reset = 1'b0; reset_b = 1'b0;

        // Frame 0, solid white, full-rate enable.
        hs_hi = 0; vs_hi = 0; fs_cnt = 0; white = 0; map_err = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick(1'b1);
            if (i == 0) begin
                check("first_fs", 32'(fs_a), 32'd1);
                check("first_hs", 32'(hs_a), 32'd1);
                check("first_vs", 32'(vs_a), 32'd1);
                check("first_hs_b", 32'(hs_b), 32'd0);
                check("first_fs_b", 32'(fs_b), 32'd1);
            end
            if (i == HS - 1) check("hs_last_hi", 32'(hs_a), 32'd1);
            if (i == HS)     check("hs_first_lo", 32'(hs_a), 32'd0);
            if (i == HT)     check("hs_line1", 32'(hs_a), 32'd1);
            hs_hi  += int'(hs_a);
            vs_hi  += int'(vs_a);
            fs_cnt += int'(fs_a);
            white  += int'(col_a() == 12'hFFF);
            exp_act = (shown_h >= HST) && (shown_h < HST + HA) && (shown_v >= VST) && (shown_v < VST + VA);
            if ((col_a() == 12'hFFF) != exp_act || (col_a() != 12'hFFF && col_a() != 12'h000))
                map_err++;
        end
        check("hs_high_clks", 32'(hs_hi), 32'(HS * VT));
        check("vs_high_clks", 32'(vs_hi), 32'(VS * HT));
        check("frame_fs_cnt", 32'(fs_cnt), 32'd1);
        check("white_count", 32'(white), 32'(HA * VA));
        check("white_map_err", 32'(map_err), 32'd0);
        mode = 2'd0;
        tick(1'b1);
        check("frame_len_fs", 32'(fs_a), 32'd1);

        // Frame 1, passthrough.
        advance_to(12, 5);
        check("blank_req", 32'(pixel_req_a), 32'd0);
        check("blank_px", 32'(pixel_x_a), 32'd0);
        advance_to(23, 8);
        check("px_10", 32'(pixel_x_a), 32'd10);
        check("py_3", 32'(pixel_y_a), 32'd3);
        check("req_in", 32'(pixel_req_a), 32'd1);
        tick(1'b1);
        check("pass_a35", 32'(col_a()), 32'hA35);

        // 1-in-4 enable across the frame 1 -> 2 boundary; mode 2 is latched there.
        mode = 2'd2;
        advance_to(70, 46);
        prev_hs = hs_a; fs_cnt = 0; hold_err = 0; clk_idx = 0; rise0 = -1; rise1 = -1;
        for (int i = 0; i < 200; i++) begin
            tick(1'b1);
            clk_idx++;
            fs_cnt += int'(fs_a);
            if (hs_a && !prev_hs) begin
                if (rise0 < 0) rise0 = clk_idx;
                else if (rise1 < 0) rise1 = clk_idx;
            end
            prev_hs = hs_a;
            snap = {hs_a, vs_a, col_a()};
            for (int k = 0; k < 3; k++) begin
                tick(1'b0);
                clk_idx++;
                fs_cnt += int'(fs_a);
                if ({hs_a, vs_a, col_a()} != snap) hold_err++;
            end
        end
        check("en4_line_len", 32'(rise1 - rise0), 32'(4 * HT));
        check("en4_hold", 32'(hold_err), 32'd0);
        check("en4_fs_width", 32'(fs_cnt), 32'd1);

        // Frame 2, colour bars (bar width 8).
        advance_to(14, 5); check("bar_x0", 32'(col_a()), 32'hFFF);
        advance_to(21, 5); check("bar_x7", 32'(col_a()), 32'hFFF);
        advance_to(22, 5); check("bar_x8", 32'(col_a()), 32'hFF0);
        advance_to(30, 5); check("bar_x16", 32'(col_a()), 32'h0FF);
        advance_to(54, 5); check("bar_x40", 32'(col_a()), 32'hF00);
        advance_to(77, 5); check("bar_x63", 32'(col_a()), 32'h000);
        advance_to(13, 6); check("bar_blank", 32'(col_a()), 32'h000);
        advance_to(14, 6); check("bar_line2_x0", 32'(col_a()), 32'hFFF);
        advance_to(0, 20);
        mode = 2'd3;
        advance_to(22, 30); check("bar_after_chg", 32'(col_a()), 32'hFF0);

        // Frame 3, checkerboard.
        advance_to(30, 5);  check("chk_16_0", 32'(col_a()), 32'hFFF);
        advance_to(29, 21); check("chk_15_16", 32'(col_a()), 32'hFFF);
        advance_to(30, 21); check("chk_16_16", 32'(col_a()), 32'h000);

        // Mid-frame reset of the inverted-polarity instance.
        advance_to(0, 30);
        check("b_pre_rst_hs", 32'(hs_b), 32'd0);
        reset_b = 1'b1;
        tick(1'b1);
        check("b_rst_hs", 32'(hs_b), 32'd1);
        check("b_rst_vs", 32'(vs_b), 32'd1);
        check("b_rst_fs", 32'(fs_b), 32'd0);
        check("b_rst_col", 32'({r_b, g_b, b_b}), 32'h000);
        reset_b = 1'b0;
        tick(1'b1);
        check("b_post_fs", 32'(fs_b), 32'd1);
        check("b_post_hs", 32'(hs_b), 32'd0);
        check("b_post_vs", 32'(vs_b), 32'd0);
        repeat (HS - 1) tick(1'b1);
        check("b_hs_h7", 32'(hs_b), 32'd0);
        tick(1'b1);
        check("b_hs_h8", 32'(hs_b), 32'd1);
        check("b_fs_low", 32'(fs_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
